product_bcd_converter: RTL and testbench

Sequential binary-to-BCD stage directly downstream of the 8-bit signed multiplier. It captures the 16-bit two's-complement product {A,B} when the multiplier finishes and converts its magnitude to five BCD digits by shift-add-3 (double dabble), one bit per clock. The sign, digits and status flags drive the board's hex-display decode. Previous results stay stable on the outputs throughout a new conversion.

---
 rtl/product_bcd_pkg.sv | 17 +
 rtl/bcd_digit_adjust.sv | 12 +
 rtl/product_bcd_converter.sv | 106 ++++++++++
 tb/tb_product_bcd_converter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/product_bcd_pkg.sv
// Shared types and constants for the signed-product to BCD converter.
// Holds the FSM state encoding and the shift-add-3 adjustment constants.
package product_bcd_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_DIGITS = 5;

   localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd5;
   localparam logic [3:0] BCD_ADJ_VALUE     = 4'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } bcd_state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Combinational double-dabble correction for one BCD nibble:
// adds 3 whenever the digit is 5 or more, so the next left shift carries correctly.
module bcd_digit_adjust
   import product_bcd_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   assign adjusted = (digit >= BCD_ADJ_THRESHOLD) ? (digit + BCD_ADJ_VALUE) : digit;

endmodule

// File: rtl/product_bcd_converter.sv
// Captures a signed multiplier product and converts its magnitude to BCD,
// one bit per clock; the previous Sign/Bcd stay on the outputs until the new result lands.
module product_bcd_converter
   import product_bcd_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DIGITS = DEF_DIGITS
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic [WIDTH-1:0]      Product,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Sign,
   output logic [4*DIGITS-1:0]   Bcd
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   bcd_state_t       state, nx_state;
   logic [BW-1:0]    scratch, nx_scratch;
   logic [WIDTH-1:0] mag, nx_mag;
   logic [CW-1:0]    count, nx_count;
   logic             sign_cap, nx_sign_cap;
   logic             nx_sign;
   logic [BW-1:0]    nx_bcd;

   logic [BW-1:0]    adj;
   logic [BW-1:0]    shifted;
   logic             accept;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_adj
         bcd_digit_adjust u_adj (
            .digit    (scratch[4*g +: 4]),
            .adjusted (adj[4*g +: 4])
         );
      end
   endgenerate

   // Scratch and magnitude shift as one long word: magnitude MSB feeds the ones nibble.
   assign shifted = {adj[BW-2:0], mag[WIDTH-1]};
   assign accept  = Start && ((state == IDLE) || (state == DONE));
   assign Busy    = (state == SHIFT);
   assign Done    = (state == DONE);

   always_comb begin
      nx_state    = state;
      nx_scratch  = scratch;
      nx_mag      = mag;
      nx_count    = count;
      nx_sign_cap = sign_cap;
      nx_sign     = Sign;
      nx_bcd      = Bcd;
      if (accept) begin
         // 0x8000 negates to itself and is simply read as unsigned 32768.
         nx_sign_cap = Product[WIDTH-1];
         nx_mag      = Product[WIDTH-1] ? (~Product + 1'b1) : Product;
         nx_scratch  = '0;
         nx_count    = '0;
         nx_state    = SHIFT;
      end else begin
         case (state)
            IDLE: nx_state = IDLE;
            SHIFT: begin
               nx_scratch = shifted;
               nx_mag     = {mag[WIDTH-2:0], 1'b0};
               if (count == LAST_BIT) begin
                  nx_bcd   = shifted;
                  nx_sign  = sign_cap;
                  nx_state = DONE;
               end else begin
                  nx_count = count + 1'b1;
               end
            end
            DONE:    nx_state = IDLE;
            default: nx_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         scratch  <= '0;
         mag      <= '0;
         count    <= '0;
         sign_cap <= 1'b0;
         Sign     <= 1'b0;
         Bcd      <= '0;
      end else begin
         state    <= nx_state;
         scratch  <= nx_scratch;
         mag      <= nx_mag;
         count    <= nx_count;
         sign_cap <= nx_sign_cap;
         Sign     <= nx_sign;
         Bcd      <= nx_bcd;
      end
   end

endmodule

// File: tb/tb_product_bcd_converter.sv
// Scoreboard bench for product_bcd_converter: expected sign/digits are queued
// from a decimal reference model at accept time and compared on every Done pulse.
module tb_product_bcd_converter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Start;
   logic [15:0] Product;
   logic        Busy;
   logic        Done;
   logic        Sign;
   logic [19:0] Bcd;

   int n_checks   = 0;
   int n_fail     = 0;
   int done_count = 0;

   logic [20:0] sb[$];
   logic        prev_sign = 1'b0;
   logic [19:0] prev_bcd  = '0;

   product_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .Start   (Start),
      .Product (Product),
      .Busy    (Busy),
      .Done    (Done),
      .Sign    (Sign),
      .Bcd     (Bcd)
   );

   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [20:0] model(input logic [15:0] p);
      int          v;
      int          m;
      logic        s;
      logic [19:0] d;
      v = int'($signed(p));
      s = (v < 0);
      m = s ? -v : v;
      d = '0;
      for (int i = 0; i < 5; i++) begin
         d[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return {s, d};
   endfunction

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   always @(negedge Clk) begin
      if (Done === 1'b1) begin
         logic [20:0] e;
         done_count++;
         check_eq("busy_during_done", 32'(Busy), 32'd0);
         if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check_eq("sign", 32'(Sign), 32'(e[20]));
            check_eq("bcd", 32'(Bcd), 32'(e[19:0]));
            prev_sign = e[20];
            prev_bcd  = e[19:0];
         end
      end
   end

   task automatic convert(input logic [15:0] p, input int pulse_at, input string tag);
      int k;
      int busy_n;
      int dc0;
      bit seen;
      dc0     = done_count;
      Product = p;
      Start   = 1'b1;
      sb.push_back(model(p));
      tick;
      Product = ~p;
      busy_n  = Busy ? 1 : 0;
      seen    = 1'b0;
      for (k = 1; k <= 40; k++) begin
         Start = (k == pulse_at);
         tick;
         if (Done) begin
            seen = 1'b1;
            break;
         end
         if (Busy) busy_n++;
         check_eq({tag, "_hold_bcd"}, 32'(Bcd), 32'(prev_bcd));
         check_eq({tag, "_hold_sign"}, 32'(Sign), 32'(prev_sign));
      end
      Start = 1'b0;
      check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
      check_eq({tag, "_latency"}, 32'(k), 32'd16);
      check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'd16);
      tick;
      tick;
      check_eq({tag, "_done_pulses"}, 32'(done_count - dc0), 32'd1);
      check_eq({tag, "_idle_after"}, 32'(Busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int k;
      int j;
      int dc0;
      Reset   = 1'b1;
      Start   = 1'b0;
      Product = '0;
      tick;
      tick;
      Reset = 1'b0;
      check_eq("rst_busy", 32'(Busy), 32'd0);
      check_eq("rst_done", 32'(Done), 32'd0);
      check_eq("rst_sign", 32'(Sign), 32'd0);
      check_eq("rst_bcd", 32'(Bcd), 32'd0);

      Reset   = 1'b1;
      Start   = 1'b1;
      Product = 16'h0001;
      tick;
      Reset = 1'b0;
      Start = 1'b0;
      tick;
      check_eq("rst_priority_busy", 32'(Busy), 32'd0);

      convert(16'h4000, -1, "p4000");
      convert(16'hC080, -1, "pC080");
      convert(16'h0000, -1, "p0000");
      convert(16'h8000, -1, "p8000");
      convert(16'hFFF9, 5, "pFFF9");

      Product = 16'h0015;
      Start   = 1'b1;
      sb.push_back(model(16'h0015));
      tick;
      Product = 16'h00FF;
      for (k = 1; k <= 40; k++) begin
         tick;
         if (Done) break;
      end
      check_eq("b2b_first_latency", 32'(k), 32'd16);
      sb.push_back(model(16'h00FF));
      for (j = 1; j <= 40; j++) begin
         tick;
         if (Done) break;
      end
      check_eq("b2b_spacing", 32'(j), 32'd17);
      Start = 1'b0;
      tick;
      tick;

      Product = 16'h1234;
      Start   = 1'b1;
      tick;
      Start = 1'b0;
      repeat (8) tick;
      Reset = 1'b1;
      tick;
      check_eq("abort_busy", 32'(Busy), 32'd0);
      check_eq("abort_done", 32'(Done), 32'd0);
      check_eq("abort_sign", 32'(Sign), 32'd0);
      check_eq("abort_bcd", 32'(Bcd), 32'd0);
      Reset = 1'b0;
      dc0   = done_count;
      repeat (25) tick;
      check_eq("abort_no_done", 32'(done_count - dc0), 32'd0);
      check_eq("abort_idle", 32'(Busy), 32'd0);
      prev_sign = 1'b0;
      prev_bcd  = '0;
      convert(16'h1234, -1, "p1234");

      check_eq("sb_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
